sync_edge_detect_mc: RTL and testbench

- Parametrised multi-channel successor to the two-flop synchroniser/rising-edge detector.
- Brings NCH asynchronous level signals into the clk domain through a configurable-depth synchroniser.
- Applies a per-channel stability (glitch) filter, then emits single-cycle edge pulses, selectable per channel as rise, fall or both.
- Sticky per-channel event flags with software clear; sits at the receive side of any slow-to-fast or async-to-sync control crossing.

---
 rtl/sync_pkg.sv | 15 +
 rtl/sync_edge_chan.sv | 86 ++++++++
 rtl/sync_edge_detect_mc.sv | 37 +++
 tb/tb_sync_edge_detect_mc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for the multi-channel synchroniser / edge detector.
package sync_pkg;

    // Per-channel edge-select encodings (two bits per channel on mode_i).
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Filter counter width: must hold 0..FILT_CYCLES without wrapping.
    function automatic int unsigned cnt_width(input int unsigned filt_cycles);
        return $clog2(filt_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_edge_chan.sv
// Single channel: synchroniser chain, stability filter, edge pulse and sticky flag.
module sync_edge_chan
    import sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 1,
    parameter bit          INIT_LVL    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       async_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       level_o,
    output logic       pulse_o,
    output logic       event_o
);

    localparam int unsigned    CntW   = cnt_width(FILT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_lvl;
    logic                   lvl_q, lvl_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   event_q, event_d;
    logic                   upd;

    // Plain shift chain; nothing between stages so each flop can resolve.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], async_i};
    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Filter: accept the new level only after FILT_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        upd   = 1'b0;
        if (sync_lvl != lvl_q) begin
            if (cnt_q == CntMax) begin
                lvl_d = sync_lvl;
                upd   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Pulse qualifies the update against the edge select sampled this cycle.
    always_comb begin
        pulse_d = 1'b0;
        case (mode_i)
            MODE_RISE: pulse_d = upd & sync_lvl;
            MODE_FALL: pulse_d = upd & ~sync_lvl;
            MODE_BOTH: pulse_d = upd;
            default:   pulse_d = 1'b0;
        endcase
    end

    // Sticky flag follows the registered pulse, so a clear coinciding with pulse_o loses.
    always_comb begin
        event_d = pulse_q | (event_q & ~clr_i);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{INIT_LVL}};
            lvl_q   <= INIT_LVL;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            event_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            event_q <= event_d;
        end
    end

    assign level_o = lvl_q;
    assign pulse_o = pulse_q;
    assign event_o = event_q;

endmodule

// File: rtl/sync_edge_detect_mc.sv
// Multi-channel synchroniser / filtered edge detector: one independent channel per bit.
module sync_edge_detect_mc
    import sync_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 1,
    parameter bit          INIT_LVL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   async_i,
    input  logic [2*NCH-1:0] mode_i,
    input  logic [NCH-1:0]   clr_i,
    output logic [NCH-1:0]   level_o,
    output logic [NCH-1:0]   pulse_o,
    output logic [NCH-1:0]   event_o
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        sync_edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .INIT_LVL    (INIT_LVL)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .async_i (async_i[i]),
            .mode_i  (mode_i[2*i +: 2]),
            .clr_i   (clr_i[i]),
            .level_o (level_o[i]),
            .pulse_o (pulse_o[i]),
            .event_o (event_o[i])
        );
    end

endmodule

// File: tb/tb_sync_edge_detect_mc.sv
// Directed bench: default instance plus a FILT_CYCLES=4 instance for glitch rejection.
module tb_sync_edge_detect_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] async_a, clr_a, level_a, pulse_a, event_a;
    logic [7:0] mode_a;
    logic [3:0] async_b, clr_b, level_b, pulse_b, event_b;
    logic [7:0] mode_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_edge_detect_mc dut (
        .clk     (clk),
        .rst     (rst),
        .async_i (async_a),
        .mode_i  (mode_a),
        .clr_i   (clr_a),
        .level_o (level_a),
        .pulse_o (pulse_a),
        .event_o (event_a)
    );

    sync_edge_detect_mc #(
        .FILT_CYCLES (4)
    ) dut_f4 (
        .clk     (clk),
        .rst     (rst),
        .async_i (async_b),
        .mode_i  (mode_b),
        .clr_i   (clr_b),
        .level_o (level_b),
        .pulse_o (pulse_b),
        .event_o (event_b)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        async_a = '0;
        clr_a   = '0;
        mode_a  = '0;
        async_b = '0;
        clr_b   = '0;
        mode_b  = '0;
        tick(2);
        chk("rst_level", level_a, 4'h0);
        chk("rst_pulse", pulse_a, 4'h0);
        chk("rst_event", event_a, 4'h0);
        rst = 1'b0;
        tick(2);

        // ch0 rise, ch1 both, ch2 fall, ch3 rise
        mode_a     = 8'b01_10_11_01;
        async_a[0] = 1'b1;
        tick(2);
        chk("ch0_e2_level", level_a, 4'h0);
        chk("ch0_e2_pulse", pulse_a, 4'h0);
        tick(1);
        chk("ch0_e3_level", level_a, 4'h1);
        chk("ch0_e3_pulse", pulse_a, 4'h1);
        tick(1);
        chk("ch0_e4_pulse", pulse_a, 4'h0);
        chk("ch0_e4_event", event_a, 4'h1);
        tick(3);
        chk("ch0_event_held", event_a, 4'h1);

        // ch2 fall-only: no pulse on rise, one on fall
        async_a[2] = 1'b1;
        tick(3);
        chk("ch2_rise_level", level_a, 4'h5);
        chk("ch2_rise_pulse", pulse_a, 4'h0);
        tick(7);
        async_a[2] = 1'b0;
        tick(3);
        chk("ch2_fall_level", level_a, 4'h1);
        chk("ch2_fall_pulse", pulse_a, 4'h4);
        tick(1);
        chk("ch2_fall_event", event_a, 4'h5);

        // ch2 off: level tracks, no pulses
        mode_a[5:4] = 2'b00;
        async_a[2]  = 1'b1;
        tick(3);
        chk("ch2_off_rise_level", level_a, 4'h5);
        chk("ch2_off_rise_pulse", pulse_a, 4'h0);
        async_a[2] = 1'b0;
        tick(3);
        chk("ch2_off_fall_level", level_a, 4'h1);
        chk("ch2_off_fall_pulse", pulse_a, 4'h0);

        clr_a = 4'hF;
        tick(1);
        clr_a = 4'h0;
        chk("clr_all_event", event_a, 4'h0);

        // ch3: clear coincident with pulse loses, clear alone wins
        async_a[3] = 1'b1;
        tick(3);
        chk("ch3_pulse", pulse_a, 4'h8);
        clr_a[3] = 1'b1;
        tick(1);
        chk("ch3_set_wins", event_a, 4'h8);
        tick(1);
        chk("ch3_clr_alone", event_a, 4'h0);
        clr_a = 4'h0;

        // settle everything low before reset test
        async_a = 4'h0;
        tick(4);
        chk("settle_level", level_a, 4'h0);
        chk("settle_pulse_rise_only", event_a, 4'h0);

        // reset one cycle after ch0 rises
        async_a[0] = 1'b1;
        tick(1);
        rst = 1'b1;
        #1;
        chk("midrst_level", level_a, 4'h0);
        chk("midrst_pulse", pulse_a, 4'h0);
        tick(2);
        chk("midrst_hold_level", level_a, 4'h0);
        chk("midrst_hold_event", event_a, 4'h0);
        rst = 1'b0;
        tick(2);
        chk("postrst_e2_pulse", pulse_a, 4'h0);
        tick(1);
        chk("postrst_e3_pulse", pulse_a, 4'h1);
        chk("postrst_e3_level", level_a, 4'h1);
        tick(1);
        chk("postrst_e4_pulse", pulse_a, 4'h0);

        // all channels rise together
        async_a = 4'h0;
        clr_a   = 4'hF;
        tick(4);
        clr_a   = 4'h0;
        mode_a  = 8'b01_01_01_01;
        async_a = 4'hF;
        tick(3);
        chk("all_pulse", pulse_a, 4'hF);
        chk("all_level", level_a, 4'hF);
        tick(1);
        chk("all_pulse_end", pulse_a, 4'h0);
        chk("all_event", event_a, 4'hF);

        // FILT_CYCLES=4 instance, ch1 both edges
        mode_b     = 8'b00_00_11_00;
        async_b[1] = 1'b1;
        tick(3);
        async_b[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("f4_glitch_pulse", pulse_b, 4'h0);
            chk("f4_glitch_level", level_b, 4'h0);
            tick(1);
        end
        tick(2);
        async_b[1] = 1'b1;
        tick(4);
        async_b[1] = 1'b0;
        tick(1);
        chk("f4_e5_level", level_b, 4'h0);
        chk("f4_e5_pulse", pulse_b, 4'h0);
        tick(1);
        chk("f4_e6_level", level_b, 4'h2);
        chk("f4_e6_pulse", pulse_b, 4'h2);
        tick(1);
        chk("f4_e7_pulse", pulse_b, 4'h0);
        tick(2);
        chk("f4_e9_level", level_b, 4'h2);
        chk("f4_e9_pulse", pulse_b, 4'h0);
        tick(1);
        chk("f4_e10_level", level_b, 4'h0);
        chk("f4_e10_pulse", pulse_b, 4'h2);
        tick(1);
        chk("f4_e11_pulse", pulse_b, 4'h0);
        chk("f4_e11_event", event_b, 4'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
